// File: rtl/sobel_pkg.sv
// Shared defaults and types for the Sobel window generator and its bench.
package sobel_pkg;

    localparam int PIX_W_DEF      = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    // Index k holds window pixel pk: rows top..bottom, columns left..right.
    typedef logic [PIX_W_DEF-1:0] window_t [9];

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of storage; read-first so rdata shows the previous line's
// pixel at addr while the current pixel is written in its place.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEF,
    parameter int PIX_W = PIX_W_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Turns a raster pixel stream into registered 3x3 interior windows, one clock
// after the accepting edge; no backpressure, border positions emit nothing.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             frame_done
);

    logic [COL_W-1:0] col_q, cur_col, nxt_col;
    logic [ROW_W-1:0] row_q, cur_row, nxt_row;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [PIX_W-1:0] win [9];
    logic             last_col, last_row;

    // in_sof overrides the counters so the accepted pixel is always (0,0).
    always_comb begin
        cur_col  = in_sof ? '0 : col_q;
        cur_row  = in_sof ? '0 : row_q;
        last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
        last_row = (cur_row == ROW_W'(IMG_HEIGHT - 1));
        nxt_col  = cur_col + 1'b1;
        nxt_row  = cur_row;
        if (last_col) begin
            nxt_col = '0;
            nxt_row = last_row ? '0 : cur_row + 1'b1;
        end
    end

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W), .AW(COL_W)) u_lb0 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_col),
        .wdata (in_pixel),
        .rdata (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W), .AW(COL_W)) u_lb1 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                col_q <= nxt_col;
                row_q <= nxt_row;
                // Shift left by one column; lb1/lb0/input form the new right column.
                for (int k = 0; k < 3; k++) begin
                    win[3*k]     <= win[3*k + 1];
                    win[3*k + 1] <= win[3*k + 2];
                end
                win[2]     <= lb1_rd;
                win[5]     <= lb0_rd;
                win[8]     <= in_pixel;
                out_valid  <= (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
                frame_done <= last_row && last_col;
                out_row    <= cur_row - 1'b1;
                out_col    <= cur_col - 1'b1;
            end
        end
    end

    assign p0 = win[0];
    assign p1 = win[1];
    assign p2 = win[2];
    assign p3 = win[3];
    assign p4 = win[4];
    assign p5 = win[5];
    assign p6 = win[6];
    assign p7 = win[7];
    assign p8 = win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 image with hand-derived windows.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_sof;
    logic [7:0]    in_pixel;
    logic          out_valid;
    logic          frame_done;
    logic [7:0]    p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ramp (r<<4)|c, mode 1: flat 0x80, mode 2: vertical edge at col 2.
    function automatic logic [7:0] pix_of(input int mode, input int r, input int c);
        logic [7:0] v;
        case (mode)
            0:       v = 8'((r << 4) | c);
            1:       v = 8'h80;
            default: v = (c >= 2) ? 8'hFF : 8'h00;
        endcase
        return v;
    endfunction

    // Approximate gradient magnitude: each axis saturated to 255, sum saturated.
    function automatic int sobel_mag();
        int gx, gy, ax, ay, m;
        gx = (int'(p2) + 2 * int'(p5) + int'(p8)) - (int'(p0) + 2 * int'(p3) + int'(p6));
        gy = (int'(p6) + 2 * int'(p7) + int'(p8)) - (int'(p0) + 2 * int'(p1) + int'(p2));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (ax > 255) ax = 255;
        if (ay > 255) ay = 255;
        m = ax + ay;
        return (m > 255) ? 255 : m;
    endfunction

    task automatic send(input logic [7:0] pix, input logic sof);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 72'(out_valid), 72'(0));
        chk({tag, "_done"},  72'(frame_done), 72'(0));
        chk({tag, "_win"},   {p0, p1, p2, p3, p4, p5, p6, p7, p8}, 72'(0));
        chk({tag, "_rowcol"}, 72'({out_row, out_col}), 72'(0));
    endtask

    task automatic run_frame(input int mode, input bit use_sof, input bit bubbles);
        int         nwin;
        int         esob;
        window_t    ew;
        logic [71:0] exp_win;
        nwin = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (bubbles && $urandom_range(0, 2) == 0) begin
                    @(posedge clk);
                    #1;
                    chk("bubble_valid", 72'(out_valid), 72'(0));
                    chk("bubble_done", 72'(frame_done), 72'(0));
                end
                send(pix_of(mode, r, c), use_sof && r == 0 && c == 0);
                nwin += int'(out_valid);
                chk("valid", 72'(out_valid), 72'(r >= 2 && c >= 2));
                chk("frame_done", 72'(frame_done), 72'(r == H - 1 && c == W - 1));
                if (r >= 2 && c >= 2) begin
                    for (int k = 0; k < 9; k++) begin
                        ew[k] = pix_of(mode, r - 2 + k / 3, c - 2 + k % 3);
                    end
                    exp_win = {ew[0], ew[1], ew[2], ew[3], ew[4], ew[5], ew[6], ew[7], ew[8]};
                    chk("window", {p0, p1, p2, p3, p4, p5, p6, p7, p8}, exp_win);
                    chk("out_row", 72'(out_row), 72'(r - 1));
                    chk("out_col", 72'(out_col), 72'(c - 1));
                    if (mode == 0 && r == H - 1 && c == W - 1) begin
                        chk("last_p8", 72'(p8), 72'(8'h34));
                    end
                    if (mode != 0) begin
                        esob = (mode == 2 && (c - 1 == 1 || c - 1 == 2)) ? 255 : 0;
                        chk("sobel_mag", 72'(sobel_mag()), 72'(esob));
                    end
                end
            end
        end
        chk("win_count", 72'(nwin), 72'((W - 2) * (H - 2)));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Ramp frame, continuous valid: first window, borders, count, frame_done.
        run_frame(0, 1'b1, 1'b0);

        // Same frame with idle bubbles.
        run_frame(0, 1'b1, 1'b1);

        // Abandon a partial frame after 7 pixels by restarting with in_sof.
        for (int i = 0; i < 7; i++) begin
            send(pix_of(0, i / W, i % W), i == 0);
            chk("partial_valid", 72'(out_valid), 72'(0));
        end
        run_frame(0, 1'b1, 1'b0);

        // Reset while pixel (2,3) is offered; next frame starts without in_sof.
        for (int i = 0; i < 2 * W + 3; i++) begin
            send(pix_of(0, i / W, i % W), i == 0);
        end
        in_valid = 1'b1;
        in_pixel = pix_of(0, 2, 3);
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_all_zero("midrst");
        run_frame(0, 1'b0, 1'b0);

        // Back-to-back flat frame and vertical-edge frame.
        run_frame(1, 1'b1, 1'b0);
        run_frame(2, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        chk("idle_valid", 72'(out_valid), 72'(0));
        chk("idle_done", 72'(frame_done), 72'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
